stp_serializer: RTL

STP_SERIALIZER -- requirements
Module: stp_serializer

---
 rtl/stp_pkg.sv | 15 +
 rtl/stp_bit_timer.sv | 46 ++++
 rtl/stp_serializer.sv | 111 +++++++++++
 3 files changed

// File: rtl/stp_pkg.sv
// Shared definitions for the STP serial link: FSM state encoding and the
// default word width / bit period used by the serializer, the matching
// serial-in receiver and any bench that talks to them.
package stp_pkg;

  localparam int unsigned STP_BUS_WIDTH  = 3;  // bits per word
  localparam int unsigned STP_BIT_CYCLES = 1;  // clk cycles per serial bit

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } stp_state_e;

endpackage

// File: rtl/stp_bit_timer.sv
// Bit-period timer for the STP serializer.
// Counts clk cycles while run_i is high and raises tick_o on the last cycle
// of every BIT_CYCLES-long bit period; the tick doubles as the serial strobe.
//   clk     in   clock, rising edge
//   rst     in   asynchronous reset, active low
//   clr_i   in   restart the period count (word accepted)
//   run_i   in   count enable (serializer shifting)
//   tick_o  out  last cycle of the current bit period
module stp_bit_timer
  import stp_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = STP_BIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned   CW   = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == LAST);

  // Count restarts at zero after every tick, so it never exceeds LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stp_serializer.sv
// STP serializer: accepts a parallel word with a valid/ready handshake and
// sends it LSB first on ser_data, with a one-cycle ser_en strobe at the end
// of each bit period for a downstream serial-in (MSB-entry) receiver.
//
//   state  | meaning
//   IDLE   | waiting for start_valid; start_ready high (after reset release)
//   SHIFT  | bits in flight; ser_data = shift register bit 0
//   DONE   | one cycle, tx_done high, then back to IDLE
//
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   start_valid  in   request to transmit tx_data
//   start_ready  out  word can be accepted this cycle
//   tx_data      in   BUS_WIDTH word, sampled only at acceptance
//   ser_data     out  serial bit, LSB first; 0 outside SHIFT
//   ser_en       out  strobe on the last cycle of each bit period
//   busy         out  high from acceptance through DONE
//   tx_done      out  one-cycle pulse after the last strobe
module stp_serializer
  import stp_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = STP_BUS_WIDTH,
  parameter int unsigned BIT_CYCLES = STP_BIT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [BUS_WIDTH-1:0] tx_data,
  output logic                 ser_data,
  output logic                 ser_en,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned   BW       = $clog2(BUS_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(BUS_WIDTH - 1);

  stp_state_e           state_q, state_d;
  logic [BUS_WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 live_q;
  logic                 accept;
  logic                 bit_tick;

  // live_q holds start_ready low during reset and until the first edge
  // after release, even though the FSM already sits in IDLE.
  assign start_ready = live_q && (state_q == ST_IDLE);
  assign accept      = start_valid && start_ready;

  stp_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .run_i (state_q == ST_SHIFT),
    .tick_o(bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sreg_d    = tx_data;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_tick) begin
          sreg_d    = sreg_q >> 1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      live_q    <= 1'b1;
    end
  end

  // The timer only ticks in SHIFT, so ser_en needs no extra state qualifier.
  assign ser_en   = bit_tick;
  assign ser_data = (state_q == ST_SHIFT) && sreg_q[0];
  assign busy     = (state_q != ST_IDLE);
  assign tx_done  = (state_q == ST_DONE);

endmodule
